// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-memory responder: the in-flight response
// record and the width helper for its latency down-counter.
package instr_mem_pkg;

  localparam int unsigned RESP_CNT_W = 16;

  typedef struct packed {
    logic [31:0]           rdata;
    logic                  err;
    logic [RESP_CNT_W-1:0] cnt;
  } instr_resp_t;

  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/instr_resp_fifo.sv
// Circular FIFO of in-flight fetch responses; every valid entry counts its
// remaining latency down to zero while it waits to reach the head.
module instr_resp_fifo
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  instr_resp_t                  push_data_i,
  input  logic                         pop_i,
  output instr_resp_t                  head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  instr_resp_t      r_entry [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Push is applied after pop so a full FIFO can recycle the head slot in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && (r_entry[i].cnt != '0)) begin
          r_entry[i].cnt <= r_entry[i].cnt - RESP_CNT_W'(1);
        end
      end
      if (pop_i) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= next_ptr(r_rd_ptr);
      end
      if (push_i) begin
        r_entry[r_wr_ptr] <= push_data_i;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= next_ptr(r_wr_ptr);
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_entry[r_rd_ptr];
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign count_o = r_count;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: grant with optional wait, in-order responses
// after a fixed latency. Define INSTR_MEM_ERR_INJ_EN to enable the error window.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned GNT_WAIT  = 0,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] ERR_BASE  = 32'hFFFF_0000,
  parameter logic [31:0] ERR_LIMIT = 32'hFFFF_FFFF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       instr_req_i,
  input  logic [31:0]                instr_addr_i,
  output logic                       instr_gnt_o,
  output logic                       instr_rvalid_o,
  output logic [31:0]                instr_rdata_o,
  output logic                       instr_err_o,
  input  logic                       mem_we_i,
  input  logic [31:0]                mem_waddr_i,
  input  logic [31:0]                mem_wdata_i,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       busy_o
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  logic [31:0]   r_mem [MEM_WORDS];
  logic [31:0]   w_mem_rdata;
  logic          w_wait_ok;
  logic          w_gnt;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_in_err;
  logic [CW-1:0] w_count;
  instr_resp_t   w_head;
  instr_resp_t   w_push_data;
  logic          w_unused;

  always_ff @(posedge clk_i) begin
    if (mem_we_i) begin
      r_mem[mem_waddr_i[2+:AW]] <= mem_wdata_i;
    end
  end

  // Combinational read ahead of the edge: a same-cycle backdoor write is not seen.
  assign w_mem_rdata = r_mem[instr_addr_i[2+:AW]];

  if (GNT_WAIT == 0) begin : g_no_wait
    assign w_wait_ok = 1'b1;
  end else begin : g_wait
    localparam int unsigned WW = $clog2(GNT_WAIT + 1);
    logic [WW-1:0] r_wait_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i || !instr_req_i || w_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WW'(GNT_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end
    end

    assign w_wait_ok = (r_wait_cnt >= WW'(GNT_WAIT));
  end

`ifdef INSTR_MEM_ERR_INJ_EN
  assign w_in_err = (instr_addr_i >= ERR_BASE) && (instr_addr_i <= ERR_LIMIT);
  assign w_unused = ^{instr_addr_i[1:0], mem_waddr_i[1:0], mem_waddr_i[31:2+AW]};
`else
  assign w_in_err = 1'b0;
  assign w_unused = ^{instr_addr_i[1:0], instr_addr_i[31:2+AW],
                      mem_waddr_i[1:0], mem_waddr_i[31:2+AW], ERR_BASE, ERR_LIMIT};
`endif

  always_comb begin
    w_push_data       = '0;
    w_push_data.rdata = w_in_err ? '0 : w_mem_rdata;
    w_push_data.err   = w_in_err;
    w_push_data.cnt   = RESP_CNT_W'(LAT_LOAD);
  end

  assign w_pop = !rst_i && !w_empty && (w_head.cnt == '0);
  assign w_gnt = !rst_i && instr_req_i && w_wait_ok && (!w_full || w_pop);

  instr_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_gnt),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  assign instr_gnt_o    = w_gnt;
  assign instr_rvalid_o = w_pop;
  assign instr_rdata_o  = w_pop ? w_head.rdata : '0;
  assign instr_err_o    = w_pop ? w_head.err : 1'b0;
  assign outstanding_o  = rst_i ? '0 : w_count;
  assign busy_o         = (outstanding_o != '0);

endmodule
